// File: rtl/posit_to_float_pipe.sv
// posit_to_float_pipe: posit(N,ES) -> IEEE-754 converter.
// Three stages (decode, align, round/pack) with valid/ready on both sides.
module posit_to_float_pipe #(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int FSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     posit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FSIZE-1:0] float_bits,
  output logic [2:0]       flags
);
  localparam int EW   = (FSIZE == 16) ? 5 : (FSIZE == 32) ? 8 : 11;
  localparam int MW   = FSIZE - 1 - EW;
  localparam int FW   = N - 3;
  localparam int RW   = $clog2(N) + 1;
  localparam int KW   = RW + 1;
  localparam int BEW  = 16;
  localparam int XW   = N + 3;
  localparam int BIAS = 2 ** (EW - 1) - 1;
  localparam int EMAX = 2 ** EW - 1;
  localparam logic signed [BEW-1:0] BE_MAX = BEW'(EMAX);
  localparam logic signed [BEW-1:0] BE_MIN = '0;

  logic r1_v, r2_v, r3_v;
  logic w_en1, w_en2, w_en3;

  assign w_en3    = !r3_v || out_ready;
  assign w_en2    = !r2_v || w_en3;
  assign w_en1    = !r1_v || w_en2;
  assign in_ready = w_en1;

  // decode
  logic [N-1:0]          w_abs;
  logic [N-2:0]          w_body;
  logic [RW-1:0]         w_run;
  logic                  w_stop;
  logic signed [KW-1:0]  w_rk;
  logic signed [KW-1:0]  w_k;
  logic [XW-1:0]         w_x;
  logic [XW-1:0]         w_xf;
  logic [3:0]            w_exp;
  logic [FW-1:0]         w_frac;
  logic                  w_zero;
  logic                  w_nar;
  logic                  w_unused;

  assign w_abs  = posit[N-1] ? -posit : posit;
  assign w_body = w_abs[N-2:0];
  assign w_zero = (posit == '0);
  assign w_nar  = posit[N-1] && (posit[N-2:0] == '0);

  always_comb begin
    w_run  = '0;
    w_stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!w_stop && (w_body[i] == w_body[N-2]))
        w_run = w_run + RW'(1);
      else
        w_stop = 1'b1;
    end
  end

  assign w_rk = $signed(KW'(w_run));
  assign w_k  = w_body[N-2] ? (w_rk - KW'(1)) : -w_rk;

  // drop regime + terminator; exponent then fraction are left-aligned
  assign w_x    = {w_body, 4'b0000} << (w_run + RW'(1));
  assign w_exp  = w_x[XW-1 -: 4] >> (4 - ES);
  assign w_xf   = w_x << ES;
  assign w_frac = w_xf[XW-1 -: FW];

  assign w_unused = ^{w_abs[N-1], w_x[XW-5:0], w_xf[XW-FW-1:0]};

  logic                 r1_sign, r1_zero, r1_nar;
  logic signed [KW-1:0] r1_k;
  logic [3:0]           r1_exp;
  logic [FW-1:0]        r1_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_v    <= 1'b0;
      r1_sign <= 1'b0;
      r1_zero <= 1'b0;
      r1_nar  <= 1'b0;
      r1_k    <= '0;
      r1_exp  <= '0;
      r1_frac <= '0;
    end else if (w_en1) begin
      r1_v <= in_valid;
      if (in_valid) begin
        r1_sign <= posit[N-1];
        r1_zero <= w_zero;
        r1_nar  <= w_nar;
        r1_k    <= w_k;
        r1_exp  <= w_exp;
        r1_frac <= w_frac;
      end
    end
  end

  // align
  logic signed [BEW-1:0] w_be;
  logic [FW+MW+1:0]      w_fx;

  assign w_be = (BEW'(r1_k) <<< ES) + $signed(BEW'(r1_exp)) + BEW'(BIAS);
  assign w_fx = {r1_frac, {(MW+2){1'b0}}};

  logic                  r2_sign, r2_zero, r2_nar;
  logic signed [BEW-1:0] r2_be;
  logic [MW-1:0]         r2_mant;
  logic                  r2_g, r2_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_v    <= 1'b0;
      r2_sign <= 1'b0;
      r2_zero <= 1'b0;
      r2_nar  <= 1'b0;
      r2_be   <= '0;
      r2_mant <= '0;
      r2_g    <= 1'b0;
      r2_s    <= 1'b0;
    end else if (w_en2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_sign <= r1_sign;
        r2_zero <= r1_zero;
        r2_nar  <= r1_nar;
        r2_be   <= w_be;
        r2_mant <= w_fx[FW+MW+1 -: MW];
        r2_g    <= w_fx[FW+1];
        r2_s    <= |w_fx[FW:0];
      end
    end
  end

  // round / pack
  logic                  w_up;
  logic [MW:0]           w_mr;
  logic signed [BEW-1:0] w_ber;
  logic [FSIZE-1:0]      w_bits;
  logic [2:0]            w_flags;

  assign w_up  = r2_g && (r2_s || r2_mant[0]);
  assign w_mr  = {1'b0, r2_mant} + (MW+1)'(w_up);
  assign w_ber = r2_be + $signed(BEW'(w_mr[MW]));

  always_comb begin
    w_bits  = '0;
    w_flags = '0;
    if (r2_nar) begin
      w_bits = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if (r2_zero) begin
      w_bits = '0;
    end else if (w_ber >= BE_MAX) begin
      w_bits  = {r2_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_flags = 3'b101;
    end else if (w_ber <= BE_MIN) begin
      w_bits  = {r2_sign, {(FSIZE-1){1'b0}}};
      w_flags = 3'b011;
    end else begin
      w_bits  = {r2_sign, w_ber[EW-1:0], w_mr[MW-1:0]};
      w_flags = {2'b00, r2_g | r2_s};
    end
  end

  logic [FSIZE-1:0] r3_bits;
  logic [2:0]       r3_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_v     <= 1'b0;
      r3_bits  <= '0;
      r3_flags <= '0;
    end else if (w_en3) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r3_bits  <= w_bits;
        r3_flags <= w_flags;
      end
    end
  end

  assign out_valid  = r3_v;
  assign float_bits = r3_bits;
  assign flags      = r3_flags;

endmodule

// File: tb/tb_posit_to_float_pipe.sv
// tb_posit_to_float_pipe: three converter configurations checked
// against a value-level posit/float model plus literal vectors.
module tb_posit_to_float_pipe;
  typedef struct {
    logic [63:0] bits;
    logic [2:0]  fl;
  } exp_t;

  localparam int LN  [3] = '{16, 32, 16};
  localparam int LES [3] = '{1, 2, 1};
  localparam int LFS [3] = '{32, 32, 16};

  logic        clk, rst;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pin [3];
  logic [31:0] fb_a, fb_b;
  logic [15:0] fb_c;
  logic [2:0]  fl_a, fl_b, fl_c;
  logic [63:0] got [3];
  logic [2:0]  gfl [3];

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q [3][$];
  exp_t e_cmp;

  posit_to_float_pipe #(.N(16), .ES(1), .FSIZE(32)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .posit(pin[0][15:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .float_bits(fb_a), .flags(fl_a));

  posit_to_float_pipe #(.N(32), .ES(2), .FSIZE(32)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .posit(pin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .float_bits(fb_b), .flags(fl_b));

  posit_to_float_pipe #(.N(16), .ES(1), .FSIZE(16)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .posit(pin[2][15:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .float_bits(fb_c), .flags(fl_c));

  always_comb begin
    got[0] = {32'h0, fb_a};
    got[1] = {32'h0, fb_b};
    got[2] = {48'h0, fb_c};
    gfl[0] = fl_a;
    gfl[1] = fl_b;
    gfl[2] = fl_c;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // value-level model: posit -> (sign, scale, fraction) -> float
  function automatic exp_t model(input logic [31:0] pi, input int n,
                                 input int es, input int fs);
    exp_t        r;
    int          ew, mw, bias, i, run, k, e, sc, be;
    logic [31:0] p, a, msk;
    logic        sgn, first, inx, up;
    logic [63:0] mant, one;
    real         rem, half;
    ew   = (fs == 16) ? 5 : (fs == 32) ? 8 : 11;
    mw   = fs - 1 - ew;
    bias = (1 << (ew - 1)) - 1;
    msk  = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    p    = pi & msk;
    one  = 64'h1;
    r.bits = '0;
    r.fl   = '0;
    if (p == 32'h0) return r;
    if (p == (32'h1 << (n - 1))) begin
      r.bits = (((one << ew) - one) << mw) | (one << (mw - 1));
      return r;
    end
    sgn = p[n-1];
    a   = sgn ? ((~p + 32'h1) & msk) : p;
    i = n - 2;
    first = a[i];
    run = 0;
    while (i >= 0 && a[i] == first) begin
      run++;
      i--;
    end
    k = first ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < es; j++) begin
      e = 2 * e + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    rem  = 0.0;
    half = 0.5;
    while (i >= 0) begin
      if (a[i]) rem += half;
      half /= 2.0;
      i--;
    end
    mant = '0;
    for (int b = 0; b < mw; b++) begin
      rem  = rem * 2.0;
      mant = mant << 1;
      if (rem >= 1.0) begin
        mant |= one;
        rem -= 1.0;
      end
    end
    inx = (rem != 0.0);
    up  = (rem > 0.5) || ((rem == 0.5) && mant[0]);
    sc  = k * (1 << es) + e;
    if (up) mant++;
    if (mant == (one << mw)) begin
      mant = '0;
      sc++;
    end
    be = sc + bias;
    if (be >= (1 << ew) - 1) begin
      r.bits = (64'(sgn) << (fs - 1)) | (((one << ew) - one) << mw);
      r.fl   = 3'b101;
    end else if (be <= 0) begin
      r.bits = 64'(sgn) << (fs - 1);
      r.fl   = 3'b011;
    end else begin
      r.bits = (64'(sgn) << (fs - 1)) | (64'(be) << mw) | mant;
      r.fl   = {2'b00, inx};
    end
    return r;
  endfunction

  // scoreboard: one check per output transfer, one push per input transfer
  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) q[l].delete();
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (out_valid[l] && out_ready[l]) begin
          n_vec++;
          if (q[l].size() == 0) begin
            n_bad++;
            $display("FAIL spurious lane%0d got=%h flags=%b required=no output",
                     l, got[l], gfl[l]);
          end else begin
            e_cmp = q[l].pop_front();
            if (got[l] !== e_cmp.bits || gfl[l] !== e_cmp.fl) begin
              n_bad++;
              $display("FAIL result lane%0d got=%h/%b required=%h/%b",
                       l, got[l], gfl[l], e_cmp.bits, e_cmp.fl);
            end
          end
        end
        if (in_valid[l] && in_ready[l])
          q[l].push_back(model(pin[l], LN[l], LES[l], LFS[l]));
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] w);
    n_vec++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, g, w);
    end
  endtask

  task automatic lit(input int l, input logic [31:0] p,
                     input logic [63:0] wb, input logic [2:0] wf);
    exp_t m;
    m = model(p, LN[l], LES[l], LFS[l]);
    n_vec++;
    if (m.bits !== wb || m.fl !== wf) begin
      n_bad++;
      $display("FAIL lit lane%0d posit=%h model=%h/%b required=%h/%b",
               l, p, m.bits, m.fl, wb, wf);
    end
  endtask

  // call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int l, input logic [31:0] v);
    int   t;
    logic acc;
    pin[l] = v;
    in_valid[l] = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 40) begin
      @(negedge clk);
      acc = in_ready[l];
      @(posedge clk);
      #1;
      t++;
    end
    in_valid[l] = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send lane%0d posit=%h in_ready=0 required=1", l, v);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() + q[1].size() + q[2].size() != 0 || out_valid != 3'b000)
           && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  logic [31:0] vec_a [12] = '{32'h4000, 32'hC000, 32'h4800, 32'h5000,
                              32'h7FFF, 32'h0001, 32'h0000, 32'h8000,
                              32'h9234, 32'h0123, 32'h6ABC, 32'hFFFF};
  logic [31:0] vec_b [8]  = '{32'h40000001, 32'h40000010, 32'h40000018,
                              32'hB7654321, 32'h00000003, 32'h7FFFFFF0,
                              32'h80000000, 32'h12345678};
  logic [31:0] vec_c [8]  = '{32'h7FFF, 32'h0001, 32'h4000, 32'h7000,
                              32'h0800, 32'h1234, 32'hC800, 32'h8001};

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    for (int l = 0; l < 3; l++) pin[l] = '0;

    lit(0, 32'h4000, 64'h3F800000, 3'b000);
    lit(0, 32'hC000, 64'hBF800000, 3'b000);
    lit(0, 32'h4800, 64'h3FC00000, 3'b000);
    lit(0, 32'h5000, 64'h40000000, 3'b000);
    lit(0, 32'h7FFF, 64'h4D800000, 3'b000);
    lit(0, 32'h0001, 64'h31800000, 3'b000);
    lit(0, 32'h0000, 64'h00000000, 3'b000);
    lit(0, 32'h8000, 64'h7FC00000, 3'b000);
    lit(1, 32'h40000001, 64'h3F800000, 3'b001);
    lit(1, 32'h40000010, 64'h3F800001, 3'b000);
    lit(1, 32'h40000018, 64'h3F800002, 3'b001);
    lit(2, 32'h7FFF, 64'h7C00, 3'b101);
    lit(2, 32'h0001, 64'h0000, 3'b011);
    lit(2, 32'h4000, 64'h3C00, 3'b000);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_float_a", got[0], 64'd0);
    chk("reset_flags_a", 64'(gfl[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'h7);

    // latency without backpressure
    send(0, 32'h4000);
    lat = 1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk("latency_cycles", 64'(lat), 64'd3);
    @(posedge clk);
    #1;
    drain();

    fork
      foreach (vec_a[i]) send(0, vec_a[i]);
      foreach (vec_b[i]) send(1, vec_b[i]);
      foreach (vec_c[i]) send(2, vec_c[i]);
    join
    drain();

    // backpressure on lane 0
    out_ready[0] = 1'b0;
    fork
      begin
        send(0, 32'h4000);
        send(0, 32'h4800);
        send(0, 32'h5000);
        send(0, 32'hC000);
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          @(negedge clk);
          if (k >= 4) begin
            chk("stall_out_valid", 64'(out_valid[0]), 64'd1);
            chk("stall_hold_bits", got[0], 64'h3F800000);
            chk("stall_in_ready", 64'(in_ready[0]), 64'd0);
          end
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("drain_no_gap", 64'(out_valid[0]), 64'd1);
        end
        @(negedge clk);
        chk("drain_empty", 64'(out_valid[0]), 64'd0);
        chk("drain_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
      end
    join
    drain();

    // asynchronous reset with all three stages occupied
    out_ready[0] = 1'b0;
    send(0, 32'h4000);
    send(0, 32'h4800);
    send(0, 32'h5000);
    chk("prereset_valid", 64'(out_valid[0]), 64'd1);
    chk("prereset_full", 64'(in_ready[0]), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_bits", got[0], 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    chk("postrst_valid", 64'(out_valid), 64'd0);
    chk("postrst_ready", 64'(in_ready), 64'h7);
    send(0, 32'h4000);
    drain();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
